// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: round-robin share of one cache-bus port among PORT_NUM requesters.
// Define CACHE_BUS_ARB_PERF_EN to add per-port grant/wait counters on perf_o.

module cache_bus_arbiter #(
   parameter int PORT_NUM = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LEN_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PORT_NUM-1:0]      up_req_valid_i,
   output logic [PORT_NUM-1:0]      up_req_ready_o,
   input  logic [PORT_NUM-1:0]      up_req_write_i,
   input  logic [PORT_NUM*ADDR_W-1:0] up_req_addr_i,
   input  logic [PORT_NUM*LEN_W-1:0]  up_req_len_i,
   input  logic [PORT_NUM*DATA_W-1:0] up_wdata_i,
   input  logic [PORT_NUM-1:0]      up_wvalid_i,
   output logic [PORT_NUM-1:0]      up_wready_o,
   output logic [DATA_W-1:0]        up_rdata_o,
   output logic [PORT_NUM-1:0]      up_rvalid_o,
   output logic                     up_rlast_o,
   output logic [PORT_NUM-1:0]      up_bvalid_o,
   output logic                     dn_req_valid_o,
   input  logic                     dn_req_ready_i,
   output logic                     dn_req_write_o,
   output logic [ADDR_W-1:0]        dn_req_addr_o,
   output logic [LEN_W-1:0]         dn_req_len_o,
   output logic [DATA_W-1:0]        dn_wdata_o,
   output logic                     dn_wvalid_o,
   input  logic                     dn_wready_i,
   output logic                     dn_wlast_o,
   input  logic [DATA_W-1:0]        dn_rdata_i,
   input  logic                     dn_rvalid_i,
   input  logic                     dn_rlast_i,
   input  logic                     dn_bvalid_i
`ifdef CACHE_BUS_ARB_PERF_EN
   ,
   output logic [PORT_NUM*64-1:0]   perf_o
`endif
);

   localparam int IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

   typedef enum logic [2:0] {IDLE, REQ, RD, WR, WB} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, grant_q, sel_idx;
   logic             sel_found;
   logic             write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0] len_q, beat_cnt_q;
   logic             req_hs, w_hs, w_last;

   // first valid port at or above rr_ptr, wrapping
   always_comb begin : sel_search
      int p;
      p         = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         p = int'(rr_ptr_q) + i;
         if (p >= PORT_NUM) p = p - PORT_NUM;
         if (!sel_found && up_req_valid_i[p]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(p);
         end
      end
   end

   assign req_hs = (state_q == REQ) && dn_req_ready_i;
   assign w_hs   = (state_q == WR) && up_wvalid_i[grant_q] && dn_wready_i;
   assign w_last = (beat_cnt_q == len_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (sel_found) state_d = REQ;
         REQ:  if (dn_req_ready_i) state_d = write_q ? WR : RD;
         RD:   if (dn_rvalid_i && dn_rlast_i) state_d = IDLE;
         WR:   if (w_hs && w_last) state_d = WB;
         WB:   if (dn_bvalid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         if (state_q == IDLE && sel_found) begin
            grant_q <= sel_idx;
            write_q <= up_req_write_i[sel_idx];
            addr_q  <= up_req_addr_i[sel_idx*ADDR_W +: ADDR_W];
            len_q   <= up_req_len_i[sel_idx*LEN_W +: LEN_W];
         end
         if (req_hs) begin
            rr_ptr_q   <= (grant_q == IDX_W'(PORT_NUM-1)) ? '0 : grant_q + 1'b1;
            beat_cnt_q <= '0;
         end
         if (w_hs) beat_cnt_q <= beat_cnt_q + 1'b1;
      end
   end

   always_comb begin
      up_req_ready_o = '0;
      up_wready_o    = '0;
      up_rdata_o     = '0;
      up_rvalid_o    = '0;
      up_rlast_o     = 1'b0;
      up_bvalid_o    = '0;
      dn_req_valid_o = 1'b0;
      dn_req_write_o = 1'b0;
      dn_req_addr_o  = '0;
      dn_req_len_o   = '0;
      dn_wdata_o     = '0;
      dn_wvalid_o    = 1'b0;
      dn_wlast_o     = 1'b0;
      unique case (state_q)
         IDLE: ;
         REQ: begin
            dn_req_valid_o          = 1'b1;
            dn_req_write_o          = write_q;
            dn_req_addr_o           = addr_q;
            dn_req_len_o            = len_q;
            up_req_ready_o[grant_q] = dn_req_ready_i;
         end
         RD: begin
            up_rdata_o           = dn_rdata_i;
            up_rvalid_o[grant_q] = dn_rvalid_i;
            up_rlast_o           = dn_rvalid_i & dn_rlast_i;
         end
         WR: begin
            dn_wvalid_o          = up_wvalid_i[grant_q];
            dn_wdata_o           = up_wdata_i[grant_q*DATA_W +: DATA_W];
            up_wready_o[grant_q] = dn_wready_i;
            dn_wlast_o           = w_last;
         end
         WB: up_bvalid_o[grant_q] = dn_bvalid_i;
         default: ;
      endcase
   end

`ifdef CACHE_BUS_ARB_PERF_EN
   logic [31:0] grant_cnt [PORT_NUM];
   logic [31:0] wait_cnt  [PORT_NUM];

   // saturating counters; a port waits until its request is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < PORT_NUM; p++) begin
            grant_cnt[p] <= '0;
            wait_cnt[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < PORT_NUM; p++) begin
            if (up_req_ready_o[p] && grant_cnt[p] != '1)
               grant_cnt[p] <= grant_cnt[p] + 1'b1;
            if (up_req_valid_i[p] && !up_req_ready_o[p] && wait_cnt[p] != '1)
               wait_cnt[p] <= wait_cnt[p] + 1'b1;
         end
      end
   end

   always_comb begin
      perf_o = '0;
      for (int p = 0; p < PORT_NUM; p++)
         perf_o[p*64 +: 64] = {wait_cnt[p], grant_cnt[p]};
   end
`endif

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares one downstream cache-bus port (toward the AXI converter) between N upstream cache requesters, e.g. icache, dcache, uncached/cacop writeback.
- Grants exactly one requester per transaction, read or write burst.
- Holds the grant until the transaction completes.
- Uses round-robin priority so no requester starves.

Parameters:
- PORT_NUM, 2, number of upstream requesters (2..4).
- ADDR_W, 32, address width.
- DATA_W, 32, beat data width.
- LEN_W, 8, burst length field; value = beats-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- up_req_valid_i  in  PORT_NUM  request valid per port.
- up_req_ready_o  out  PORT_NUM  request accepted (one-hot or zero).
- up_req_write_i  in  PORT_NUM  1 = write burst.
- up_req_addr_i  in  PORT_NUM*ADDR_W  burst start address.
- up_req_len_i  in  PORT_NUM*LEN_W  beats-1.
- up_wdata_i  in  PORT_NUM*DATA_W  write beat data.
- up_wvalid_i  in  PORT_NUM  write beat valid.
- up_wready_o  out  PORT_NUM  write beat accepted.
- up_rdata_o  out  DATA_W  read data, broadcast to all ports.
- up_rvalid_o  out  PORT_NUM  read beat valid, granted port only.
- up_rlast_o  out  1  last read beat.
- up_bvalid_o  out  PORT_NUM  write complete, granted port only.
- dn_req_valid_o / dn_req_ready_i / dn_req_write_o / dn_req_addr_o / dn_req_len_o  mirror of upstream request, single port.
- dn_wdata_o  out  DATA_W  forwarded write data.
- dn_wvalid_o  out  1  forwarded write valid.
- dn_wready_i  in  1  downstream write ready.
- dn_wlast_o  out  1  asserted on beat number len.
- dn_rdata_i  in  DATA_W  read data.
- dn_rvalid_i  in  1  read beat valid.
- dn_rlast_i  in  1  last read beat.
- dn_bvalid_i  in  1  write response.

Behaviour:
- States: IDLE, REQ, RD, WR, WB.
- Reset:
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - All valid/ready/last outputs 0; data outputs 0.
- IDLE:
  - If any up_req_valid_i is set, select the first valid port searching upward from rr_ptr, wrapping modulo PORT_NUM.
  - Latch grant, write, addr and len into registers; go to REQ next cycle.
  - Arbitration is registered: 1-cycle decision latency.
- REQ:
  - dn_req_valid_o=1 with latched fields.
  - On dn_req_ready_i:
    - Pulse up_req_ready_o[grant] in the same cycle.
    - Set rr_ptr=(grant+1) mod PORT_NUM.
    - Go to RD if read, WR if write; beat_cnt=0.
  - Upstream must hold req_valid and fields until up_req_ready_o; the arbiter ignores later changes.
- RD:
  - Pass dn_rdata_i combinationally to up_rdata_o.
  - up_rvalid_o[grant]=dn_rvalid_i; up_rlast_o=dn_rvalid_i&dn_rlast_i.
  - On dn_rvalid_i&dn_rlast_i, go to IDLE.
  - Non-granted rvalid bits are always 0.
- WR:
  - dn_wvalid_o=up_wvalid_i[grant]; dn_wdata_o=selected wdata.
  - up_wready_o[grant]=dn_wready_i.
  - dn_wlast_o=(beat_cnt==len).
  - beat_cnt increments on each wvalid&wready.
  - On the handshake with wlast, go to WB.
- WB:
  - up_bvalid_o[grant]=dn_bvalid_i.
  - On dn_bvalid_i, go to IDLE.
- A new grant is issued only from IDLE: minimum 1 idle cycle between transactions.
- Boundary cases:
  - len=0: single beat, wlast on first beat.
  - len=2^LEN_W-1: beat_cnt is LEN_W bits and must not wrap before the compare.
  - All ports requesting together: strict rotation.
  - A sole requester re-requesting is granted again despite rr_ptr.
  - Reset mid-burst: immediate return to IDLE, outputs cleared; downstream is reset in the same domain.
  - A requester dropping valid in IDLE before grant is legal; no grant is issued to it.

Optional Feature:
- Macro: CACHE_BUS_ARB_PERF_EN.
- Defined:
  - Per-port 32-bit counters grant_cnt_o[p] (increment on each up_req_ready_o[p]).
  - Per-port 32-bit counters wait_cnt_o[p] (increment each cycle up_req_valid_i[p]=1 and not yet granted).
  - Counters saturate at 0xFFFFFFFF and reset to 0.
  - Extra output port perf_o, PORT_NUM*64 bits: {wait,grant} per port.
- Undefined: no counters and no perf_o port; all other behaviour identical.

Test Plan:
- Single read, port1, addr 0x1C000000, len 3 → dn_req_addr_o=0x1C000000 and dn_req_len_o=3 one cycle after valid; 4 rvalid beats routed only to port1; rlast on beat 4; back to IDLE.
- Ports 0 and 1 both request reads continuously, 6 transactions → grant order 0,1,0,1,0,1; never two consecutive grants to one port while the other waits.
- Write, port0, len 0, data 0xDEADBEEF → dn_wlast_o=1 on the first beat with dn_wdata_o=0xDEADBEEF; up_bvalid_o[0] pulses on dn_bvalid_i.
- Write len 7 with dn_wready_i toggling 1,0,1,0 → exactly 8 beats forwarded in order; wlast only on the 8th accepted beat.
- Assert rst during RD beat 2 of 4 → next cycle all outputs 0, state IDLE; a fresh request is granted normally.
- With CACHE_BUS_ARB_PERF_EN, port1 waits 3 cycles then is granted once → grant_cnt[1]=1, wait_cnt[1]=3.
